// File: rtl/bru_pkg.sv
// Shared definitions for the execute-stage branch resolution logic:
// datapath width, RISC-V branch condition codes and the squash FSM states.
package bru_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    SQ_IDLE   = 1'b0,
    SQ_SQUASH = 1'b1
  } sq_state_e;

  // True when exactly one of the three control-flow type flags is set.
  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational conditional-branch comparator, selected by funct3.
// Reserved codes (010/011) resolve as not taken.
module branch_cond_eval
  import bru_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: computes direction/target, flags mispredicts,
// drives registered update/flush pulses to fetch and squashes wrong-path slots.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             in_is_branch,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pred_pc,
  output logic             branch_taken_execute,
  output logic [XLEN-1:0]  pc_execute,
  output logic [XLEN-1:0]  target_pc_execute,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             target_misaligned,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int SQ_W = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES);
  localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);

  sq_state_e        state_q;
  logic [SQ_W-1:0]  sq_cnt_q;

  logic             taken_q;
  logic             flush_q;
  logic             misaligned_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  target_q;
  logic [XLEN-1:0]  redirect_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  logic             cond_taken;
  logic             accept;
  logic             taken_d;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target_d;
  logic [XLEN-1:0]  correct_next_d;
  logic             mispredict_d;

  branch_cond_eval u_cond (
    .funct3 (in_funct3),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .taken  (cond_taken)
  );

  // Squashed slots and malformed multi-type instructions are never accepted.
  assign accept = !stall && in_valid && (state_q == SQ_IDLE)
                  && one_hot3(in_is_branch, in_is_jal, in_is_jalr);

  assign jalr_sum       = in_rs1 + in_imm;
  assign target_d       = in_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
  assign taken_d        = in_is_branch ? cond_taken : 1'b1;
  assign correct_next_d = taken_d ? target_d : (in_pc + PC_INC);
  assign mispredict_d   = (correct_next_d != in_pred_pc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= SQ_IDLE;
      sq_cnt_q         <= '0;
      taken_q          <= 1'b0;
      flush_q          <= 1'b0;
      misaligned_q     <= 1'b0;
      pc_q             <= '0;
      target_q         <= '0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (!stall) begin
      if (accept) begin
        taken_q      <= taken_d;
        flush_q      <= mispredict_d;
        misaligned_q <= taken_d & target_d[1];
        pc_q         <= in_pc;
        target_q     <= target_d;
        redirect_q   <= correct_next_d;
        if (branch_cnt_q != '1) begin
          branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        end
        if (mispredict_d && (mispredict_cnt_q != '1)) begin
          mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
        end
        if (mispredict_d && (SQUASH_CYCLES > 0)) begin
          state_q  <= SQ_SQUASH;
          sq_cnt_q <= SQ_LOAD;
        end
      end else begin
        // Pulses last one cycle; addresses stay for the BTB to read at leisure.
        taken_q      <= 1'b0;
        flush_q      <= 1'b0;
        misaligned_q <= 1'b0;
      end
      if (state_q == SQ_SQUASH) begin
        sq_cnt_q <= sq_cnt_q - SQ_ONE;
        if (sq_cnt_q == SQ_ONE) begin
          state_q <= SQ_IDLE;
        end
      end
    end
  end

  assign branch_taken_execute = taken_q;
  assign flush                = flush_q;
  assign target_misaligned    = misaligned_q;
  assign pc_execute           = pc_q;
  assign target_pc_execute    = target_q;
  assign redirect_pc          = redirect_q;
  assign branch_count         = branch_cnt_q;
  assign mispredict_count     = mispredict_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage branch resolution block that feeds the BTB-equipped fetch unit.
- Consumes decoded control-flow instructions from the ID/EX register, together with the predicted next PC that fetch attached to each instruction.
- Computes the actual direction and target, and detects mispredictions.
- Drives registered update and flush pulses back to fetch.
- Squashes wrong-path instructions already in flight, and keeps saturating branch and mispredict counters.

Parameters:
SQUASH_CYCLES, 2, number of accepted instruction slots ignored after a flush (wrong-path IF/ID contents).
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous active-low reset.
stall  in  1  pipeline stall; when high, every register holds its value.
in_valid  in  1  ID/EX slot holds a valid instruction.
in_is_branch  in  1  conditional branch.
in_is_jal  in  1  direct jump (PC+imm).
in_is_jalr  in  1  indirect jump ((rs1+imm) with bit 0 cleared).
in_funct3  in  3  branch condition code, RISC-V encoding.
in_pc  in  32  instruction address.
in_rs1  in  32  operand 1.
in_rs2  in  32  operand 2.
in_imm  in  32  sign-extended immediate.
in_pred_pc  in  32  next PC that fetch used after this instruction.
branch_taken_execute  out  1  resolved taken (registered pulse).
pc_execute  out  32  address of the resolved instruction (BTB index/tag).
target_pc_execute  out  32  computed target address.
flush  out  1  misprediction pulse.
redirect_pc  out  32  correct next PC, valid while flush=1.
target_misaligned  out  1  taken target with bits [1:0] != 0.
branch_count  out  CNT_W  resolved control-flow instructions.
mispredict_count  out  CNT_W  flushes issued.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, squash counter 0, counters 0. On release, the first possible output pulse is one clock after the first accepted instruction.
- Accept condition: stall=0, in_valid=1, squash counter = 0, and exactly one of is_branch/is_jal/is_jalr set.
  - Other instructions are ignored.
  - More than one type flag set: ignored and counted as nothing.
- Condition evaluation (is_branch), by funct3:
  - 000 EQ; 001 NE.
  - 100 signed LT; 101 signed GE.
  - 110 unsigned LT; 111 unsigned GE.
  - 010/011: not taken.
- Target:
  - Branch and JAL: pc+imm, modulo 2^32.
  - JALR: (rs1+imm) & ~1.
  - JAL/JALR are always taken.
- Correct next PC: taken ? target : pc+4, wrapping modulo 2^32.
- Mispredict: correct_next != in_pred_pc.
- Latency: one clock. Registered outputs update on the edge that samples the accepted instruction.
  - branch_taken_execute = taken.
  - flush = mispredict.
  - pc_execute = in_pc.
  - target_pc_execute = target.
  - redirect_pc = correct_next.
  - target_misaligned = taken & target[1].
- Pulse rules:
  - Non-stall cycle without an accepted instruction: branch_taken_execute, flush and target_misaligned clear to 0.
  - pc_execute, target_pc_execute and redirect_pc keep their last values.
  - With stall=1, all outputs hold, so a flush pulse persists until fetch can act on it.
- Squash FSM, two states:
  - IDLE: squash counter = 0.
  - SQUASH: squash counter > 0.
  - An accepted mispredict loads SQUASH_CYCLES (IDLE->SQUASH).
  - Each non-stall cycle in SQUASH decrements the counter. While in SQUASH, in_valid is treated as 0, including for counters.
  - Counter reaching 0 returns to IDLE.
  - SQUASH_CYCLES=0: the FSM never leaves IDLE.
- Counters:
  - branch_count increments on every accepted instruction.
  - mispredict_count increments on every accepted mispredict.
  - Both saturate at all-ones. No wrap.
- Reset mid-squash or mid-pulse: immediate return to reset values. A pending flush is dropped.

Decomposition:
- Shared package (bru_pkg):
  - funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - XLEN=32.
  - The PC increment constant 4.
- One natural sub-module: branch_cond_eval. Purely combinational; inputs funct3, rs1, rs2; output taken. Isolates the compare logic for reuse by a future second execute lane.
- FSM, output registers and counters stay in the top module.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x40, pred_pc=0x104 -> next cycle:
  - branch_taken_execute=1, flush=1, redirect_pc=0x140, pc_execute=0x100, mispredict_count=1.
  - The following 2 valid branches are ignored; branch_count=1.
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x20, pred_pc=0x220 -> taken (signed), flush=0.
  - The same operands with BLTU and pred_pc=0x220 -> not taken, flush=1, redirect_pc=0x204.
- JALR, rs1=0x1001, imm=0x2, pred_pc=0x1002 -> target 0x1002, flush=0, target_misaligned=1.
- Flush issued with stall raised on the same cycle for 3 cycles -> flush stays 1 and redirect_pc is stable for all 3 cycles.
  - After stall drops: flush=0 one cycle later; squash decrements only on non-stall cycles.
- CNT_W=4, 20 accepted mispredicts with SQUASH_CYCLES=0 -> mispredict_count saturates at 0xF.
  - reset_n pulsed low mid-stream -> all counters and outputs read 0 immediately.
- pc=0xFFFFFFFC, not-taken BNE (rs1=rs2), pred_pc=0x8 -> redirect_pc=0x00000000, flush=1.
